// File: rtl/riscky_pkg.sv
// Shared definitions for the riscky front end: widths, fetch FSM states and
// the PC increment used by the fetch unit.
package riscky_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int PC_STEP = 4;

    // REQ: may issue a request; WAIT: a live request is outstanding;
    // DISCARD: an outstanding request was made stale by a redirect.
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory request/response channel, the redirect
// input and the decode-side handshake of the fetch unit.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    // Memory / pipeline side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs. Flush has priority over
// push and pop; a simultaneous push and pop is accepted even when full.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset; empty slots are never presented.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one word-aligned request at a time to
// instruction memory, buffers responses with their PC and hands them to
// decode. Redirects flush the buffer and turn any in-flight request stale.
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    import riscky_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   req_pc;
    logic [XLEN-1:0]   target_pc;
    logic [CNT_W-1:0]  count;
    logic [2*XLEN-1:0] head;
    logic              full;
    logic              empty;
    logic              has_credit;
    logic              req_fire;
    logic              push;
    logic              pop;

    // Low two bits of the redirect target are cleared to keep word alignment.
    assign target_pc = bus.redirect_pc & ~XLEN'(3);

    // Only one request may be outstanding, so in REQ nothing is in flight and
    // the reserved-slot rule reduces to "the FIFO has a free entry".
    assign has_credit = !full;

    assign bus.imem_req_valid = !rst && (state == REQ) && has_credit;
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // A response in the redirect cycle belongs to the old path and is dropped.
    assign push = (state == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;

    assign bus.instr_valid = (count != '0) && !bus.redirect_valid;
    assign pop             = bus.instr_valid && bus.instr_ready;
    assign bus.instr       = empty ? '0 : head[XLEN-1:0];
    assign bus.instr_pc    = empty ? '0 : head[2*XLEN-1:XLEN];

    // Fetch FSM and program counter; a redirect overrides normal sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc <= target_pc;
            case (state)
                REQ:     state <= req_fire ? DISCARD : REQ;
                WAIT:    state <= bus.imem_rsp_valid ? REQ : DISCARD;
                DISCARD: state <= bus.imem_rsp_valid ? REQ : DISCARD;
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (req_fire) begin
                        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                DISCARD: begin
                    if (bus.imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Remember the address of the accepted request to tag its response.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            req_pc <= fetch_pc;
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({req_pc, bus.imem_rsp_data}),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .count     (count),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small variable-latency memory
// model that answers each request with addr ^ 32'hA5A5_0000.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;

    logic [31:0] req_log [$];
    logic [31:0] out_pc  [$];
    logic [31:0] out_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        tick(2);
        req_log.delete();
        out_pc.delete();
        out_data.delete();
        rst = 1'b0;
        #1;
    endtask

    // Memory model: log accepted requests, answer after mem_lat cycles.
    initial begin
        logic        fire;
        logic        pending;
        logic [31:0] faddr;
        logic [31:0] paddr;
        int          cnt;
        pending = 1'b0;
        paddr   = '0;
        cnt     = 0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            fire  = bus.imem_req_valid && bus.imem_req_ready && !rst;
            faddr = bus.imem_req_addr;
            @(negedge clk);
            bus.imem_rsp_valid = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (fire) begin
                pending = 1'b1;
                cnt     = mem_lat;
                paddr   = faddr;
                req_log.push_back(faddr);
            end
            if (pending) begin
                if (cnt <= 1) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = paddr ^ 32'hA5A5_0000;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Output monitor: record every instruction consumed by decode.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && bus.instr_valid && bus.instr_ready) begin
                out_pc.push_back(bus.instr_pc);
                out_data.push_back(bus.instr);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;

        // Reset state
        tick(2);
        chk("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid),    32'd0);
        chk("rst_instr",       bus.instr,               32'd0);
        chk("rst_instr_pc",    bus.instr_pc,            32'd0);

        // Streaming with a 1-cycle memory
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        mem_lat = 1;
        do_reset();
        chk("t1_first_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_first_addr",  bus.imem_req_addr,       32'h0);
        tick(12);
        chk("t1_req_cnt",  32'(req_log.size()), 32'd6);
        chk("t1_req0",     qget(req_log, 0), 32'h0);
        chk("t1_req1",     qget(req_log, 1), 32'h4);
        chk("t1_req2",     qget(req_log, 2), 32'h8);
        chk("t1_out_cnt",  32'(out_pc.size()), 32'd5);
        chk("t1_pc0",      qget(out_pc, 0), 32'h0);
        chk("t1_pc1",      qget(out_pc, 1), 32'h4);
        chk("t1_pc2",      qget(out_pc, 2), 32'h8);
        chk("t1_d0",       qget(out_data, 0), 32'hA5A5_0000);
        chk("t1_d1",       qget(out_data, 1), 32'hA5A5_0004);
        chk("t1_d2",       qget(out_data, 2), 32'hA5A5_0008);
        chk("t1_head_vld", 32'(bus.instr_valid), 32'd1);
        chk("t1_head_pc",  bus.instr_pc, 32'h14);

        // Decode stalled: credit limits requests to the FIFO depth
        bus.instr_ready = 1'b0;
        do_reset();
        tick(20);
        chk("t2_req_cnt",   32'(req_log.size()), 32'd4);
        chk("t2_req3",      qget(req_log, 3), 32'hC);
        chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_instr_vld", 32'(bus.instr_valid), 32'd1);
        chk("t2_head_pc",   bus.instr_pc, 32'h0);
        bus.instr_ready = 1'b1;
        tick(10);
        chk("t2_pc0",  qget(out_pc, 0), 32'h0);
        chk("t2_pc1",  qget(out_pc, 1), 32'h4);
        chk("t2_pc2",  qget(out_pc, 2), 32'h8);
        chk("t2_pc3",  qget(out_pc, 3), 32'hC);
        chk("t2_pc4",  qget(out_pc, 4), 32'h10);
        chk("t2_req4", qget(req_log, 4), 32'h10);

        // Redirect while WAITing on 0x8; the stale response arrives later
        mem_lat = 1;
        do_reset();
        tick(4);
        mem_lat = 4;
        tick(1);
        chk("t3_req2", qget(req_log, 2), 32'h8);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        chk("t3_redir_vld", 32'(bus.instr_valid), 32'd0);
        tick(1);
        bus.redirect_valid = 1'b0;
        mem_lat = 1;
        #1;
        chk("t3_discard_req", 32'(bus.imem_req_valid), 32'd0);
        tick(8);
        chk("t3_req3", qget(req_log, 3), 32'h100);
        chk("t3_pc0",  qget(out_pc, 0), 32'h0);
        chk("t3_pc1",  qget(out_pc, 1), 32'h4);
        chk("t3_pc2",  qget(out_pc, 2), 32'h100);
        chk("t3_d2",   qget(out_data, 2), 32'hA5A5_0100);
        chk("t3_pc3",  qget(out_pc, 3), 32'h104);

        // Redirect coinciding with a response, FIFO holding two entries
        bus.instr_ready = 1'b0;
        mem_lat = 1;
        do_reset();
        tick(5);
        chk("t4_pre_vld", 32'(bus.instr_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        bus.instr_ready    = 1'b1;
        #1;
        chk("t4_redir_vld", 32'(bus.instr_valid), 32'd0);
        tick(1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_empty_vld", 32'(bus.instr_valid), 32'd0);
        chk("t4_no_pop",    32'(out_pc.size()), 32'd0);
        chk("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t4_req_addr",  bus.imem_req_addr, 32'h200);
        tick(4);
        chk("t4_pc0", qget(out_pc, 0), 32'h200);

        // Request-channel backpressure
        bus.imem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("t5_hold_addr",  bus.imem_req_addr, 32'h0);
            tick(1);
        end
        chk("t5_none_yet", 32'(req_log.size()), 32'd0);
        bus.imem_req_ready = 1'b1;
        tick(1);
        chk("t5_one_xfer", 32'(req_log.size()), 32'd1);
        chk("t5_req0",     qget(req_log, 0), 32'h0);

        // PC wrap via redirect, then asynchronous reset during WAIT
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b0;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        tick(1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t6_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        tick(2);
        chk("t6_wrap_vld",  32'(bus.imem_req_valid), 32'd1);
        chk("t6_wrap_addr", bus.imem_req_addr, 32'h0);
        tick(1);
        chk("t6_pre_vld", 32'(bus.instr_valid), 32'd1);
        chk("t6_pre_pc",  bus.instr_pc, 32'hFFFF_FFFC);
        rst = 1'b1;
        #1;
        chk("t6_rst_req_vld",   32'(bus.imem_req_valid), 32'd0);
        chk("t6_rst_instr_vld", 32'(bus.instr_valid), 32'd0);
        chk("t6_rst_instr",     bus.instr, 32'd0);
        chk("t6_rst_instr_pc",  bus.instr_pc, 32'd0);
        tick(2);
        rst = 1'b0;
        #1;
        chk("t6_post_vld",  32'(bus.imem_req_valid), 32'd1);
        chk("t6_post_addr", bus.imem_req_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
